mips_mc_ctrl: RTL and testbench

Multi-cycle main controller for the MIPS datapath. It sequences instruction fetch, decode, execute, memory and writeback. It drives the 3-bit ALU function select (f_in) and the datapath mux/enable strobes each cycle. It talks to a shared instruction/data memory over a valid/ready handshake with a stall timeout.

---
 rtl/mips_pkg.sv | 60 ++++++
 rtl/mips_alu_dec.sv | 25 ++
 rtl/mips_mc_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller and its
// ALU function decoder.
package mips_pkg;

    typedef enum logic [3:0] {
        ST_RESET   = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_EXEC_R  = 4'd7,
        ST_ALUWB   = 4'd8,
        ST_ADDI_EX = 4'd9,
        ST_ADDI_WB = 4'd10,
        ST_BRANCH  = 4'd11,
        ST_JUMP    = 4'd12,
        ST_HALT    = 4'd13
    } state_e;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU function select
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-operand mux
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that hold a memory request open waiting for mem_ready
    function automatic logic is_mem_wait(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct -> ALU function decoder. Unsupported funct codes report
// valid_o=0 and fall back to ADD so the ALU select is never undefined.
module mips_alu_dec
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_f_o,
    output logic       valid_o
);

    // Map the supported funct codes onto the ALU select
    always_comb begin
        alu_f_o = ALU_ADD;
        valid_o = 1'b1;
        case (funct_i)
            FN_ADD:  alu_f_o = ALU_ADD;
            FN_SUB:  alu_f_o = ALU_SUB;
            FN_AND:  alu_f_o = ALU_AND;
            FN_OR:   alu_f_o = ALU_OR;
            FN_SLT:  alu_f_o = ALU_SLT;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/
// writeback, drives the datapath strobes and ALU select, and guards every
// memory wait with a stall timeout that parks the FSM in HALT with bus_err.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_f,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_retired,
    output logic       illegal,
    output logic       bus_err
);

    // stall_cnt_q counts wait cycles already spent on the current request;
    // the request times out on the STALL_LIMIT-th consecutive cycle without
    // mem_ready, so mem_ready in that same cycle still completes it.
    localparam logic [CNT_W-1:0] LAST_STALL = CNT_W'(STALL_LIMIT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             in_wait;
    logic             timeout;
    logic [2:0]       r_alu_f;
    logic             r_valid;

    mips_alu_dec u_alu_dec (
        .funct_i (funct),
        .alu_f_o (r_alu_f),
        .valid_o (r_valid)
    );

    // Stall counter and sticky bus error bookkeeping
    always_comb begin
        in_wait     = is_mem_wait(state_q);
        timeout     = in_wait && !mem_ready && (stall_cnt_q == LAST_STALL);
        stall_cnt_d = '0;
        if (in_wait && !mem_ready && !timeout) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        bus_err_d = bus_err_q | timeout;
    end

    // Output decode and next-state selection from the current state
    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_en         = 1'b0;
        pc_src        = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        alu_f         = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        instr_retired = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            ST_RESET: begin
                alu_f   = 3'b000;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_R:         state_d = ST_EXEC_R;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDI_EX;
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEMWB;
                end else if (timeout) begin
                    state_d = ST_HALT;
                end
            end
            ST_MEMWB: begin
                reg_write     = 1'b1;
                mem_to_reg    = 1'b1;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_d       = ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_HALT;
                end
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REGB;
                alu_f     = r_alu_f;
                if (r_valid) begin
                    state_d = ST_ALUWB;
                end else begin
                    illegal = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_ALUWB: begin
                reg_write     = 1'b1;
                reg_dst       = 1'b1;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REGB;
                alu_f         = ALU_SUB;
                pc_src        = PCSRC_ALUOUT;
                pc_en         = alu_zero;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src        = PCSRC_JUMP;
                pc_en         = 1'b1;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_HALT: begin
                alu_f = 3'b000;
            end
            default: begin
                alu_f   = 3'b000;
                state_d = ST_RESET;
            end
        endcase
    end

    assign bus_err = bus_err_q;

    // FSM state, stall counter and sticky bus error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            stall_cnt_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            bus_err_q   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: the stimulus side walks each
// instruction through its phases and queues the expected control word for
// every cycle; an independent monitor pops and compares on each falling edge.
module tb_mips_mc_ctrl;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_f;
    logic       reg_write, reg_dst, mem_to_reg, instr_retired, illegal, bus_err;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_f;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_retired;
        logic       illegal;
        logic       bus_err;
    } vec_t;

    vec_t  act;
    vec_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Values the driver applies at the start of the next cycle
    logic       nx_rst = 1'b0;
    logic [5:0] nx_op  = 6'd0;
    logic [5:0] nx_fn  = 6'd0;
    logic       nx_z   = 1'b0;

    localparam logic [5:0] FN_TAB [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    localparam logic [2:0] AF_TAB [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};
    localparam logic [5:0] OP_TAB [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    mips_mc_ctrl #(.STALL_LIMIT(LIMIT), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .alu_zero      (alu_zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_en         (pc_en),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_f         (alu_f),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .instr_retired (instr_retired),
        .illegal       (illegal),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    assign act = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                  alu_f, reg_write, reg_dst, mem_to_reg, instr_retired, illegal, bus_err};

    // Monitor: one expected control word per cycle, checked mid-cycle
    always @(negedge clk) begin
        vec_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                if (failures <= 25)
                    $display("FAIL %s t=%0t actual=%h required=%h", t, $time, act, e);
            end
        end
    end

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit op_known(input logic [5:0] op);
        for (int i = 0; i < 6; i++) if (OP_TAB[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expected ALU select for an R-type funct; ok=0 for unsupported codes
    function automatic logic [2:0] fn_alu(input logic [5:0] fn, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5; i++) if (FN_TAB[i] == fn) begin ok = 1'b1; return AF_TAB[i]; end
        return 3'b010;
    endfunction

    // Every active (non-reset, non-halt) cycle starts from ADD and all strobes low
    function automatic vec_t base();
        vec_t r;
        r       = '0;
        r.alu_f = 3'b010;
        return r;
    endfunction

    task automatic step(input vec_t e, input logic rdy, input string tag);
        @(posedge clk);
        #1;
        rst_n     = nx_rst;
        opcode    = nx_op;
        funct     = nx_fn;
        alu_zero  = nx_z;
        mem_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // A memory wait phase of w stall cycles; w >= LIMIT never completes and ends in HALT
    task automatic mem_phase(input vec_t wait_v, input vec_t done_v, input int w,
                             input string tag, output bit to);
        vec_t h;
        to = 1'b0;
        if (w >= LIMIT) begin
            for (int i = 0; i < LIMIT; i++) step(wait_v, 1'b0, {tag, "_stall"});
            h         = '0;
            h.bus_err = 1'b1;
            for (int i = 0; i < 4; i++) step(h, rnd(), "halt");
            to = 1'b1;
        end else begin
            for (int i = 0; i < w; i++) step(wait_v, 1'b0, {tag, "_stall"});
            step(done_v, 1'b1, tag);
        end
    endtask

    task automatic do_reset();
        nx_rst = 1'b0;
        step('0, rnd(), "reset_assert");
        step('0, rnd(), "reset_hold");
        nx_rst = 1'b1;
        step('0, rnd(), "reset_release");
    endtask

    // Reference sequence for one instruction: fw/mw are memory wait cycles
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                            input int mw, input logic z, output bit halted);
        vec_t     w, d, e;
        bit       ok;
        logic [2:0] af;
        nx_op = op; nx_fn = fn; nx_z = z;
        halted = 1'b0;

        w = base(); w.mem_req = 1'b1; w.alu_src_b = 2'b01;
        d = w;      d.ir_write = 1'b1; d.pc_en = 1'b1;
        mem_phase(w, d, fw, "fetch", halted);
        if (halted) return;

        e = base(); e.alu_src_b = 2'b11; e.illegal = !op_known(op);
        step(e, rnd(), "decode");
        if (!op_known(op)) return;

        case (op)
            6'b100011, 6'b101011: begin
                e = base(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                step(e, rnd(), "memadr");
                if (op == 6'b100011) begin
                    w = base(); w.mem_req = 1'b1; w.iord = 1'b1;
                    mem_phase(w, w, mw, "memrd", halted);
                    if (halted) return;
                    e = base(); e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_retired = 1'b1;
                    step(e, rnd(), "memwb");
                end else begin
                    w = base(); w.mem_req = 1'b1; w.mem_we = 1'b1; w.iord = 1'b1;
                    d = w; d.instr_retired = 1'b1;
                    mem_phase(w, d, mw, "memwr", halted);
                end
            end
            6'b000000: begin
                af = fn_alu(fn, ok);
                e = base(); e.alu_src_a = 1'b1; e.alu_f = af; e.illegal = !ok;
                step(e, rnd(), "exec_r");
                if (ok) begin
                    e = base(); e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_retired = 1'b1;
                    step(e, rnd(), "aluwb");
                end
            end
            6'b001000: begin
                e = base(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                step(e, rnd(), "addi_ex");
                e = base(); e.reg_write = 1'b1; e.instr_retired = 1'b1;
                step(e, rnd(), "addi_wb");
            end
            6'b000100: begin
                e = base(); e.alu_src_a = 1'b1; e.alu_f = 3'b110; e.pc_src = 2'b01;
                e.pc_en = z; e.instr_retired = 1'b1;
                step(e, rnd(), z ? "beq_taken" : "beq_not_taken");
            end
            default: begin
                e = base(); e.pc_src = 2'b10; e.pc_en = 1'b1; e.instr_retired = 1'b1;
                step(e, rnd(), "jump");
            end
        endcase
    endtask

    initial begin
        bit         h;
        logic [5:0] op, fn;
        int         fw, mw;

        rst_n = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0;

        // Reset: everything low, then release
        nx_rst = 1'b0;
        repeat (3) step('0, 1'b1, "reset_state");
        nx_rst = 1'b1;
        step('0, 1'b1, "reset_release");

        // Directed cases
        do_instr(6'b000000, 6'b100010, 0, 0, 1'b0, h);  // R SUB
        do_instr(6'b100011, 6'b000000, 0, 3, 1'b0, h);  // LW, 3 stalls
        do_instr(6'b000100, 6'b000000, 0, 0, 1'b1, h);  // BEQ taken
        do_instr(6'b000100, 6'b000000, 1, 0, 1'b0, h);  // BEQ not taken
        do_instr(6'b111111, 6'b000000, 0, 0, 1'b0, h);  // illegal opcode
        do_instr(6'b000000, 6'b000111, 0, 0, 1'b0, h);  // illegal funct
        do_instr(6'b101011, 6'b000000, 3, 3, 1'b0, h);  // SW, ready on the last allowed cycle
        do_instr(6'b001000, 6'b000000, 2, 0, 1'b0, h);  // ADDI
        do_instr(6'b000010, 6'b000000, 0, 0, 1'b0, h);  // J
        for (int i = 0; i < 5; i++) do_instr(6'b000000, FN_TAB[i], 0, 0, 1'b0, h);

        // Timeouts in FETCH, MEMRD and MEMWR, each recovered by reset
        do_instr(6'b000000, 6'b100000, LIMIT, 0, 1'b0, h);
        do_reset();
        do_instr(6'b100011, 6'b000000, 0, LIMIT, 1'b0, h);
        do_reset();
        do_instr(6'b101011, 6'b000000, 1, LIMIT, 1'b0, h);
        do_reset();

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do begin op = 6'($urandom); end while (op_known(op));
            end else begin
                op = OP_TAB[$urandom_range(0, 5)];
            end
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : FN_TAB[$urandom_range(0, 4)];
            fw = ($urandom_range(0, 39) == 0) ? LIMIT : $urandom_range(0, LIMIT - 1);
            mw = ($urandom_range(0, 39) == 0) ? LIMIT : $urandom_range(0, LIMIT - 1);
            do_instr(op, fn, fw, mw, rnd(), h);
            if (h) do_reset();
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
